regfile_wb_arbiter: RTL and testbench

//   Write-back controller for the 32x32 register file. Shares the single RF write

---
 rtl/regfile_wb_arbiter.sv | 136 +++++++++++++
 tb/tb_regfile_wb_arbiter.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_wb_arbiter.sv
// rtl/regfile_wb_arbiter.sv - round-robin write-back arbiter with RAW scoreboard (optional WB_FWD_EN forwarding)
module regfile_wb_arbiter #(
    parameter int N_REQ = 3,
    parameter int AW    = 5,
    parameter int DW    = 32
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [N_REQ-1:0]    req_valid,
    output logic [N_REQ-1:0]    req_ready,
    input  logic [N_REQ*AW-1:0] req_addr,
    input  logic [N_REQ*DW-1:0] req_data,
    input  logic                iss_valid,
    input  logic [AW-1:0]       iss_addr,
    input  logic [AW-1:0]       A1,
    input  logic [AW-1:0]       A2,
    output logic                stall,
    output logic [2**AW-1:0]    busy,
    output logic                wr_en,
    output logic [AW-1:0]       wr_addr,
    output logic [DW-1:0]       wr_data
`ifdef WB_FWD_EN
    ,
    input  logic [DW-1:0]       rf_rd1,
    input  logic [DW-1:0]       rf_rd2,
    output logic [DW-1:0]       fwd_rd1,
    output logic [DW-1:0]       fwd_rd2
`endif
);

    localparam int PW   = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam int NREG = 2**AW;

    logic [PW-1:0]    ptr_q, ptr_d;
    logic             wr_en_q, wr_en_d;
    logic [AW-1:0]    wr_addr_q, wr_addr_d;
    logic [DW-1:0]    wr_data_q, wr_data_d;
    logic [NREG-1:0]  busy_q, busy_d;

    logic [N_REQ-1:0] grant;
    logic [PW-1:0]    gnt_idx;
    logic             transfer;
    logic [AW-1:0]    sel_addr;
    logic [DW-1:0]    sel_data;
    logic             haz1, haz2;

    // Round-robin scan starting at the pointer; first valid requester wins, nothing granted in reset
    always_comb begin
        int  idx;
        logic found;
        grant   = '0;
        gnt_idx = '0;
        found   = 1'b0;
        idx     = 0;
        for (int i = 0; i < N_REQ; i++) begin
            idx = int'(ptr_q) + i;
            if (idx >= N_REQ) begin
                idx = idx - N_REQ;
            end
            if (!found && req_valid[idx]) begin
                found      = 1'b1;
                grant[idx] = 1'b1;
                gnt_idx    = PW'(idx);
            end
        end
        if (reset) begin
            grant = '0;
        end
    end

    assign req_ready = grant;
    assign transfer  = |grant;
    assign sel_addr  = req_addr[AW*gnt_idx +: AW];
    assign sel_data  = req_data[DW*gnt_idx +: DW];

    // Next-state: pointer advance, registered write port, scoreboard clear-then-set (set wins)
    always_comb begin
        ptr_d     = ptr_q;
        wr_en_d   = 1'b0;
        wr_addr_d = wr_addr_q;
        wr_data_d = wr_data_q;
        busy_d    = busy_q;
        if (transfer) begin
            ptr_d     = (gnt_idx == PW'(N_REQ - 1)) ? '0 : gnt_idx + 1'b1;
            wr_en_d   = (sel_addr != '0);
            wr_addr_d = sel_addr;
            wr_data_d = sel_data;
            busy_d[sel_addr] = 1'b0;
        end
        if (iss_valid && (iss_addr != '0)) begin
            busy_d[iss_addr] = 1'b1;
        end
        // x0 is hardwired zero and never has a pending writer
        busy_d[0] = 1'b0;
    end

    // State registers; reset discards any in-flight write
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ptr_q     <= '0;
            wr_en_q   <= 1'b0;
            wr_addr_q <= '0;
            wr_data_q <= '0;
            busy_q    <= '0;
        end else begin
            ptr_q     <= ptr_d;
            wr_en_q   <= wr_en_d;
            wr_addr_q <= wr_addr_d;
            wr_data_q <= wr_data_d;
            busy_q    <= busy_d;
        end
    end

    // RAW hazard per source; the in-flight write only stalls when it cannot be forwarded
    always_comb begin
`ifdef WB_FWD_EN
        haz1 = (A1 != '0) && busy_q[A1];
        haz2 = (A2 != '0) && busy_q[A2];
`else
        haz1 = (A1 != '0) && (busy_q[A1] || (wr_en_q && (wr_addr_q == A1)));
        haz2 = (A2 != '0) && (busy_q[A2] || (wr_en_q && (wr_addr_q == A2)));
`endif
    end

    assign stall   = haz1 || haz2;
    assign busy    = busy_q;
    assign wr_en   = wr_en_q;
    assign wr_addr = wr_addr_q;
    assign wr_data = wr_data_q;

`ifdef WB_FWD_EN
    assign fwd_rd1 = (wr_en_q && (wr_addr_q == A1) && (A1 != '0)) ? wr_data_q : rf_rd1;
    assign fwd_rd2 = (wr_en_q && (wr_addr_q == A2) && (A2 != '0)) ? wr_data_q : rf_rd2;
`endif

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// tb/tb_regfile_wb_arbiter.sv - directed and random check of regfile_wb_arbiter against a reference model
module tb_regfile_wb_arbiter;

    localparam int N  = 3;
    localparam int AW = 5;
    localparam int DW = 32;

    logic            clk = 1'b0;
    logic            reset;
    logic [N-1:0]    req_valid;
    logic [N-1:0]    req_ready;
    logic [N*AW-1:0] req_addr;
    logic [N*DW-1:0] req_data;
    logic            iss_valid;
    logic [AW-1:0]   iss_addr;
    logic [AW-1:0]   A1, A2;
    logic            stall;
    logic [31:0]     busy;
    logic            wr_en;
    logic [AW-1:0]   wr_addr;
    logic [DW-1:0]   wr_data;
`ifdef WB_FWD_EN
    logic [DW-1:0]   rf_rd1, rf_rd2, fwd_rd1, fwd_rd2;
`endif

    always #5 clk = ~clk;

    regfile_wb_arbiter #(.N_REQ(N), .AW(AW), .DW(DW)) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_addr(req_addr), .req_data(req_data),
        .iss_valid(iss_valid), .iss_addr(iss_addr),
        .A1(A1), .A2(A2), .stall(stall), .busy(busy),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data)
`ifdef WB_FWD_EN
        , .rf_rd1(rf_rd1), .rf_rd2(rf_rd2), .fwd_rd1(fwd_rd1), .fwd_rd2(fwd_rd2)
`endif
    );

    int vectors = 0;
    int miscompares = 0;

    // requester side: each holds its request until it is accepted
    bit            rv[N];
    logic [AW-1:0] ra[N];
    logic [DW-1:0] rd[N];

    // reference model state
    int            m_ptr;
    bit            m_busy[32];
    bit            m_wen;
    logic [AW-1:0] m_waddr;
    logic [DW-1:0] m_wdata;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_ptr = 0;
        foreach (m_busy[r]) m_busy[r] = 1'b0;
        m_wen = 1'b0;
        m_waddr = '0;
        m_wdata = '0;
    endtask

    function automatic logic [31:0] busy_vec();
        logic [31:0] v;
        for (int r = 0; r < 32; r++) v[r] = m_busy[r];
        return v;
    endfunction

    function automatic int model_grant();
        if (reset) return -1;
        for (int k = 0; k < N; k++) begin
            if (rv[(m_ptr + k) % N]) return (m_ptr + k) % N;
        end
        return -1;
    endfunction

    function automatic bit hz(input logic [AW-1:0] a);
`ifdef WB_FWD_EN
        return (a != 0) && m_busy[a];
`else
        return (a != 0) && (m_busy[a] || (m_wen && (m_waddr == a)));
`endif
    endfunction

    task automatic drive();
        for (int i = 0; i < N; i++) begin
            req_valid[i] = rv[i];
            req_addr[AW*i +: AW] = ra[i];
            req_data[DW*i +: DW] = rd[i];
        end
    endtask

    // one clock: check combinational outputs mid-cycle, then registered outputs after the edge
    task automatic step();
        int g;
        logic [N-1:0] er;
        drive();
        #3;
        g = model_grant();
        er = '0;
        if (g >= 0) er[g] = 1'b1;
        check("req_ready", 64'(req_ready), 64'(er));
        check("stall", 64'(stall), 64'(hz(A1) || hz(A2)));
`ifdef WB_FWD_EN
        check("fwd_rd1", 64'(fwd_rd1), 64'((m_wen && m_waddr == A1 && A1 != 0) ? m_wdata : rf_rd1));
        check("fwd_rd2", 64'(fwd_rd2), 64'((m_wen && m_waddr == A2 && A2 != 0) ? m_wdata : rf_rd2));
`endif
        @(posedge clk);
        #1;
        if (g >= 0) begin
            m_ptr = (g + 1) % N;
            m_wen = (ra[g] != 0);
            m_waddr = ra[g];
            m_wdata = rd[g];
            m_busy[ra[g]] = 1'b0;
            rv[g] = 1'b0;
        end else begin
            m_wen = 1'b0;
        end
        if (iss_valid && iss_addr != 0) m_busy[iss_addr] = 1'b1;
        check("wr_en", 64'(wr_en), 64'(m_wen));
        if (m_wen) begin
            check("wr_addr", 64'(wr_addr), 64'(m_waddr));
            check("wr_data", 64'(wr_data), 64'(m_wdata));
        end
        check("busy", 64'(busy), 64'(busy_vec()));
    endtask

    task automatic set_all3();
        for (int i = 0; i < N; i++) begin
            rv[i] = 1'b1;
            ra[i] = AW'(i + 1);
            rd[i] = DW'(32'hA + i);
        end
    endtask

    initial begin
        logic [AW-1:0] a;
        reset = 1'b1;
        iss_valid = 1'b0; iss_addr = '0; A1 = '0; A2 = '0;
        req_valid = '0; req_addr = '0; req_data = '0;
`ifdef WB_FWD_EN
        rf_rd1 = $urandom; rf_rd2 = $urandom;
`endif
        model_reset();
        set_all3();
        drive();
        #2;
        check("rst_ready", 64'(req_ready), 64'(0));
        check("rst_wr_en", 64'(wr_en), 64'(0));
        check("rst_wr_addr", 64'(wr_addr), 64'(0));
        check("rst_wr_data", 64'(wr_data), 64'(0));
        check("rst_busy", 64'(busy), 64'(0));
        @(posedge clk); #1;
        reset = 1'b0;

        // 1: three held requesters rotate 0,1,2,...
        for (int c = 0; c < 6; c++) begin
            set_all3();
            step();
            check("t1_wr_addr", 64'(wr_addr), 64'((c % 3) + 1));
        end
        foreach (rv[i]) rv[i] = 1'b0;
        step();

        // 2: RAW hazard on x5, cleared by write-back from requester 1
        iss_valid = 1'b1; iss_addr = 5'd5;
        step();
        iss_valid = 1'b0; A1 = 5'd5;
        step();
        check("t2_busy5_set", 64'(busy[5]), 64'(1));
        rv[1] = 1'b1; ra[1] = 5'd5; rd[1] = 32'h55;
        step();
        check("t2_busy5_clr", 64'(busy[5]), 64'(0));
        step();
        step();
        A1 = '0;

        // 3: write to x0 is accepted but never written
        rv[0] = 1'b1; ra[0] = '0; rd[0] = 32'hFFFF_FFFF;
        step();
        check("t3_wr_en", 64'(wr_en), 64'(0));

        // 4: issue and write-back of x7 on the same edge; set wins
        rv[2] = 1'b1; ra[2] = 5'd7; rd[2] = 32'h77;
        iss_valid = 1'b1; iss_addr = 5'd7;
        step();
        iss_valid = 1'b0;
        check("t4_busy7", 64'(busy[7]), 64'(1));
        rv[0] = 1'b1; ra[0] = 5'd7; rd[0] = 32'h7777;
        step();

        // 5: asynchronous reset while a write is in flight
        set_all3();
        step();
        check("t5_pre_wr_en", 64'(wr_en), 64'(1));
        reset = 1'b1;
        #1;
        check("t5_wr_en", 64'(wr_en), 64'(0));
        check("t5_busy", 64'(busy), 64'(0));
        check("t5_ready", 64'(req_ready), 64'(0));
        model_reset();
        @(posedge clk); #1;
        reset = 1'b0;
        set_all3();
        step();

        // 6: only requester 2 valid with pointer at 0
        reset = 1'b1;
        #1;
        model_reset();
        @(posedge clk); #1;
        reset = 1'b0;
        foreach (rv[i]) rv[i] = 1'b0;
        rv[2] = 1'b1; ra[2] = 5'd9; rd[2] = 32'h99;
        A1 = '0; A2 = '0;
        step();
        rv[0] = 1'b1; rv[1] = 1'b1;
        step();

        // random traffic
        for (int cyc = 0; cyc < 400; cyc++) begin
            for (int i = 0; i < N; i++) begin
                if (!rv[i] && $urandom_range(0, 1) == 1) begin
                    rv[i] = 1'b1;
                    ra[i] = AW'($urandom_range(0, 31));
                    rd[i] = $urandom;
                end
            end
            iss_valid = 1'b0;
            if ($urandom_range(0, 2) == 0) begin
                a = AW'($urandom_range(0, 31));
                if (!m_busy[a]) begin
                    iss_valid = 1'b1;
                    iss_addr = a;
                end
            end
            A1 = AW'($urandom_range(0, 31));
            A2 = AW'($urandom_range(0, 31));
            if ($urandom_range(0, 1) == 1) A1 = m_waddr;
`ifdef WB_FWD_EN
            rf_rd1 = $urandom; rf_rd2 = $urandom;
`endif
            step();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
